// File: rtl/deal_sequencer.sv
// BlackJack round controller: deals cards from the free-running counter,
// paces each card with the two-second flag and keeps both hand sums.
`timescale 1ns/1ps

module deal_sequencer #(
   parameter int CNT_WIDTH = 12
) (
   input  logic                 clk_2K,
   input  logic                 i_Reset,
   input  logic                 i_Start,
   input  logic                 i_Hit,
   input  logic                 i_Stay,
   input  logic                 i_TwoSec,
   input  logic [CNT_WIDTH-1:0] i_Count,
   output logic                 o_ActCounter,
   output logic                 o_RstCounter,
   output logic [5:0]           o_PlayerSum,
   output logic [5:0]           o_DealerSum,
   output logic [3:0]           o_Card,
   output logic [1:0]           o_Result,
   output logic                 o_Busy
);

   // state  | meaning
   // IDLE   | after reset, waiting for i_Start
   // DRAW   | one cycle: sample card, update target hand, clear counter
   // WAIT   | counter running, waiting for the two-second flag
   // PLAYER | waiting for i_Hit / i_Stay
   // DEALER | dealer draws below 17, otherwise scores the round
   // DONE   | result shown, waiting for i_Start
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRAW   = 3'd1,
      WAIT   = 3'd2,
      PLAYER = 3'd3,
      DEALER = 3'd4,
      DONE   = 3'd5
   } state_t;

   // Which part of the round a DRAW/WAIT pair belongs to; selects the
   // card target and the state WAIT returns to.
   typedef enum logic [1:0] {
      PH_DEAL   = 2'd0,
      PH_HIT    = 2'd1,
      PH_DEALER = 2'd2
   } phase_t;

   state_t     state, state_nxt;
   phase_t     phase, phase_nxt;
   logic [1:0] deal_idx, deal_idx_nxt;
   logic [5:0] player_sum, player_sum_nxt;
   logic [5:0] dealer_sum, dealer_sum_nxt;
   logic [3:0] player_soft, player_soft_nxt;
   logic [3:0] dealer_soft, dealer_soft_nxt;
   logic [3:0] card, card_nxt;
   logic [1:0] result, result_nxt;

   logic [3:0] rank;
   logic [3:0] card_val;
   logic       is_ace;
   logic       to_dealer;
   logic [5:0] base_sum, add_sum, fix_sum;
   logic [3:0] base_soft, add_soft, fix_soft;

   // Only the low nibble is the card source; upper counter bits are unused.
   logic count_unused;
   assign count_unused = ^i_Count[CNT_WIDTH-1:4];

   always_comb begin
      rank = i_Count[3:0];
      if (rank > 4'd12) begin
         rank = rank - 4'd13;
      end

      is_ace = (rank == 4'd0);
      if (is_ace) begin
         card_val = 4'd11;
      end else if (rank <= 4'd8) begin
         card_val = rank + 4'd1;
      end else begin
         card_val = 4'd10;
      end

      to_dealer = (phase == PH_DEALER) || ((phase == PH_DEAL) && (deal_idx == 2'd1));
      base_sum  = to_dealer ? dealer_sum  : player_sum;
      base_soft = to_dealer ? dealer_soft : player_soft;

      add_sum  = base_sum + {2'b00, card_val};
      add_soft = base_soft + {3'b000, is_ace};

      // One soft ace is hardened at most per card.
      if ((add_sum > 6'd21) && (add_soft != 4'd0)) begin
         fix_sum  = add_sum - 6'd10;
         fix_soft = add_soft - 4'd1;
      end else begin
         fix_sum  = add_sum;
         fix_soft = add_soft;
      end
   end

   always_comb begin
      state_nxt       = state;
      phase_nxt       = phase;
      deal_idx_nxt    = deal_idx;
      player_sum_nxt  = player_sum;
      dealer_sum_nxt  = dealer_sum;
      player_soft_nxt = player_soft;
      dealer_soft_nxt = dealer_soft;
      card_nxt        = card;
      result_nxt      = result;

      case (state)
         IDLE, DONE: begin
            if (i_Start) begin
               player_sum_nxt  = 6'd0;
               dealer_sum_nxt  = 6'd0;
               player_soft_nxt = 4'd0;
               dealer_soft_nxt = 4'd0;
               card_nxt        = 4'd0;
               result_nxt      = 2'b00;
               deal_idx_nxt    = 2'd0;
               phase_nxt       = PH_DEAL;
               state_nxt       = DRAW;
            end
         end

         DRAW: begin
            card_nxt = card_val;
            if (to_dealer) begin
               dealer_sum_nxt  = fix_sum;
               dealer_soft_nxt = fix_soft;
            end else begin
               player_sum_nxt  = fix_sum;
               player_soft_nxt = fix_soft;
            end
            state_nxt = WAIT;
         end

         WAIT: begin
            if (i_TwoSec) begin
               case (phase)
                  PH_DEAL: begin
                     if (deal_idx < 2'd2) begin
                        deal_idx_nxt = deal_idx + 2'd1;
                        state_nxt    = DRAW;
                     end else begin
                        state_nxt = PLAYER;
                     end
                  end
                  PH_HIT: begin
                     if (player_sum > 6'd21) begin
                        result_nxt = 2'b10;
                        state_nxt  = DONE;
                     end else begin
                        state_nxt = PLAYER;
                     end
                  end
                  default: state_nxt = DEALER;
               endcase
            end
         end

         PLAYER: begin
            if (i_Stay) begin
               phase_nxt = PH_DEALER;
               state_nxt = DEALER;
            end else if (i_Hit) begin
               phase_nxt = PH_HIT;
               state_nxt = DRAW;
            end
         end

         DEALER: begin
            if (dealer_sum < 6'd17) begin
               phase_nxt = PH_DEALER;
               state_nxt = DRAW;
            end else begin
               if ((dealer_sum > 6'd21) || (player_sum > dealer_sum)) begin
                  result_nxt = 2'b01;
               end else if (player_sum == dealer_sum) begin
                  result_nxt = 2'b11;
               end else begin
                  result_nxt = 2'b10;
               end
               state_nxt = DONE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_2K or negedge i_Reset) begin
      if (!i_Reset) begin
         state       <= IDLE;
         phase       <= PH_DEAL;
         deal_idx    <= 2'd0;
         player_sum  <= 6'd0;
         dealer_sum  <= 6'd0;
         player_soft <= 4'd0;
         dealer_soft <= 4'd0;
         card        <= 4'd0;
         result      <= 2'b00;
      end else begin
         state       <= state_nxt;
         phase       <= phase_nxt;
         deal_idx    <= deal_idx_nxt;
         player_sum  <= player_sum_nxt;
         dealer_sum  <= dealer_sum_nxt;
         player_soft <= player_soft_nxt;
         dealer_soft <= dealer_soft_nxt;
         card        <= card_nxt;
         result      <= result_nxt;
      end
   end

   // Counter controls and busy decode straight from the state register, so
   // reset drops them without waiting for a clock.
   assign o_ActCounter = (state == WAIT);
   assign o_RstCounter = (state == DRAW);
   assign o_Busy       = (state != IDLE) && (state != DONE);
   assign o_PlayerSum  = player_sum;
   assign o_DealerSum  = dealer_sum;
   assign o_Card       = card;
   assign o_Result     = result;

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer: deal, bust, ace softening, dealer loop,
// tie and asynchronous reset during WAIT.
`timescale 1ns/1ps

module tb_deal_sequencer;

   localparam int CNT_WIDTH = 12;

   logic                 clk_2K = 1'b0;
   logic                 i_Reset;
   logic                 i_Start;
   logic                 i_Hit;
   logic                 i_Stay;
   logic                 i_TwoSec;
   logic [CNT_WIDTH-1:0] i_Count;
   logic                 o_ActCounter;
   logic                 o_RstCounter;
   logic [5:0]           o_PlayerSum;
   logic [5:0]           o_DealerSum;
   logic [3:0]           o_Card;
   logic [1:0]           o_Result;
   logic                 o_Busy;

   int n_tests    = 0;
   int n_fail     = 0;
   int rst_pulses = 0;

   always #5 clk_2K = ~clk_2K;

   deal_sequencer #(.CNT_WIDTH(CNT_WIDTH)) dut (
      .clk_2K       (clk_2K),
      .i_Reset      (i_Reset),
      .i_Start      (i_Start),
      .i_Hit        (i_Hit),
      .i_Stay       (i_Stay),
      .i_TwoSec     (i_TwoSec),
      .i_Count      (i_Count),
      .o_ActCounter (o_ActCounter),
      .o_RstCounter (o_RstCounter),
      .o_PlayerSum  (o_PlayerSum),
      .o_DealerSum  (o_DealerSum),
      .o_Card       (o_Card),
      .o_Result     (o_Result),
      .o_Busy       (o_Busy)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check(tag, {11'd0, o_ActCounter, o_RstCounter, o_PlayerSum, o_DealerSum,
                  o_Card, o_Result, o_Busy}, 32'd0);
   endtask

   // Called at a negedge; expects DRAW now (or within a few cycles).
   task automatic deal_card(input logic [3:0] src, input int wait_n, input logic [3:0] exp_card);
      int guard;
      int act_low;
      guard   = 0;
      act_low = 0;
      while (o_RstCounter !== 1'b1 && guard < 20) begin
         @(negedge clk_2K);
         guard++;
      end
      check("draw_seen", o_RstCounter, 1);
      if (o_RstCounter === 1'b1) rst_pulses++;
      i_Count = {8'hA5, src};
      @(negedge clk_2K);
      check("rst_single", o_RstCounter, 0);
      check("act_wait", o_ActCounter, 1);
      check("card", o_Card, exp_card);
      for (int i = 1; i < wait_n; i++) begin
         @(negedge clk_2K);
         if (o_ActCounter !== 1'b1) act_low++;
      end
      check("act_hold", act_low, 0);
      i_TwoSec = 1'b1;
      @(negedge clk_2K);
      i_TwoSec = 1'b0;
   endtask

   // Called at a negedge in IDLE/DONE; returns at the negedge inside DRAW.
   task automatic start_round();
      i_Start = 1'b1;
      @(negedge clk_2K);
      i_Start = 1'b0;
      check("start_lat", o_RstCounter, 1);
      check("start_clr_ps", o_PlayerSum, 0);
      check("start_clr_ds", o_DealerSum, 0);
      check("start_clr_res", o_Result, 0);
      check("start_clr_card", o_Card, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_Reset  = 1'b0;
      i_Start  = 1'b0;
      i_Hit    = 1'b0;
      i_Stay   = 1'b0;
      i_TwoSec = 1'b0;
      i_Count  = '0;

      // Reset held with random inputs.
      repeat (6) begin
         @(negedge clk_2K);
         i_Start  = 1'($urandom);
         i_Hit    = 1'($urandom);
         i_Stay   = 1'($urandom);
         i_TwoSec = 1'($urandom);
         i_Count  = CNT_WIDTH'($urandom);
      end
      @(negedge clk_2K);
      check_zero("rst_hold");
      i_Start  = 1'b0;
      i_Hit    = 1'b0;
      i_Stay   = 1'b0;
      i_TwoSec = 1'b0;
      i_Reset  = 1'b1;
      repeat (3) @(negedge clk_2K);
      check_zero("rst_release");

      // Initial deal: player 10, dealer ace 11, player 6.
      start_round();
      deal_card(4'd9, 4096, 4'd10);
      deal_card(4'd0, 4096, 4'd11);
      deal_card(4'd5, 4096, 4'd6);
      check("deal_pulses", rst_pulses, 3);
      check("deal_ps", o_PlayerSum, 16);
      check("deal_ds", o_DealerSum, 11);
      check("deal_busy", o_Busy, 1);
      check("deal_act", o_ActCounter, 0);

      // Two-second flag has no effect in PLAYER.
      i_TwoSec = 1'b1;
      repeat (2) @(negedge clk_2K);
      i_TwoSec = 1'b0;
      check("player_twosec_rst", o_RstCounter, 0);
      check("player_twosec_act", o_ActCounter, 0);

      // Player hits a ten and busts.
      i_Hit = 1'b1;
      @(negedge clk_2K);
      i_Hit = 1'b0;
      check("hit_lat", o_RstCounter, 1);
      deal_card(4'd12, 5, 4'd10);
      check("bust_ps", o_PlayerSum, 26);
      check("bust_res", o_Result, 2);
      check("bust_busy", o_Busy, 0);

      // Hit/stay ignored in DONE.
      i_Hit  = 1'b1;
      i_Stay = 1'b1;
      repeat (3) @(negedge clk_2K);
      i_Hit  = 1'b0;
      i_Stay = 1'b0;
      check("done_hold_ps", o_PlayerSum, 26);
      check("done_hold_res", o_Result, 2);
      check("done_hold_rst", o_RstCounter, 0);

      // Ace softening: player ace, dealer 4, player ace via wrapped source 13.
      start_round();
      deal_card(4'd0, 3, 4'd11);
      deal_card(4'd3, 3, 4'd4);
      deal_card(4'd13, 3, 4'd11);
      check("ace_ps", o_PlayerSum, 12);
      check("ace_ds", o_DealerSum, 4);
      i_Hit = 1'b1;
      @(negedge clk_2K);
      i_Hit = 1'b0;
      deal_card(4'd9, 3, 4'd10);
      check("soft_hit_ps", o_PlayerSum, 12);
      check("soft_hit_busy", o_Busy, 1);
      check("soft_hit_res", o_Result, 0);
      i_Hit = 1'b1;
      @(negedge clk_2K);
      i_Hit = 1'b0;
      deal_card(4'd8, 3, 4'd9);
      check("hard_hit_ps", o_PlayerSum, 21);
      i_Stay = 1'b1;
      @(negedge clk_2K);
      i_Stay = 1'b0;
      deal_card(4'd9, 3, 4'd10);
      check("tie_ds_mid", o_DealerSum, 14);
      deal_card(4'd6, 3, 4'd7);
      @(negedge clk_2K);
      check("tie_ds", o_DealerSum, 21);
      check("tie_res", o_Result, 3);
      check("tie_busy", o_Busy, 0);

      // Dealer loop: player 18 vs dealer 11, stay beats hit.
      start_round();
      deal_card(4'd9, 3, 4'd10);
      deal_card(4'd0, 3, 4'd11);
      deal_card(4'd7, 3, 4'd8);
      check("dl_ps", o_PlayerSum, 18);
      check("dl_ds", o_DealerSum, 11);
      i_Stay = 1'b1;
      i_Hit  = 1'b1;
      @(negedge clk_2K);
      i_Stay = 1'b0;
      i_Hit  = 1'b0;
      check("stay_prio", o_RstCounter, 0);
      check("stay_busy", o_Busy, 1);
      @(negedge clk_2K);
      check("dealer_draw", o_RstCounter, 1);
      deal_card(4'd5, 3, 4'd6);
      @(negedge clk_2K);
      check("dl_ds_final", o_DealerSum, 17);
      check("dl_ps_final", o_PlayerSum, 18);
      check("dl_res", o_Result, 1);
      check("dl_busy", o_Busy, 0);

      // Asynchronous reset in the middle of a WAIT.
      start_round();
      i_Count = {8'hA5, 4'd4};
      @(negedge clk_2K);
      repeat (1999) @(negedge clk_2K);
      check("mid_wait_act", o_ActCounter, 1);
      #2;
      i_Reset = 1'b0;
      #1;
      check("async_act", o_ActCounter, 0);
      check_zero("async_all");
      @(negedge clk_2K);
      i_Reset = 1'b1;
      @(negedge clk_2K);
      check_zero("post_async");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
